// File: rtl/keccak_axis_tx.sv
// Streams a captured Keccak-f[1600] state as LANE_W-bit AXI4-Stream beats, lane 0 first.
// Optional feature: define KECCAK_TX_KEEP_EN to apply a latched TKEEP to the final beat.
module keccak_axis_tx #(
    parameter int LANES  = 25,
    parameter int LANE_W = 64
) (
    input  logic                     iSYS_CLK,
    input  logic                     iSYS_RST,
    input  logic [LANES*LANE_W-1:0]  iSTATE,
    input  logic                     iSTATE_VLD,
    input  logic [4:0]               iWORDS,
    input  logic [LANE_W/8-1:0]      iLAST_KEEP,
    output logic                     oSTATE_RDY,
    output logic                     oBUSY,
    output logic                     oDONE,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [LANE_W-1:0]        m_axis_tdata,
    output logic [LANE_W/8-1:0]      m_axis_tkeep,
    output logic                     m_axis_tlast,
    output logic [1:0]               dbg_state
);

    localparam int SW = LANES * LANE_W;
    localparam int KW = LANE_W / 8;
    localparam logic [4:0] MAX_WORDS = 5'(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_q, state_nx;
    logic [SW-1:0]   shreg_q;
    logic [4:0]      n_q;
    logic [4:0]      cnt_q;
    logic            last_q, last_nx;
    logic            capture, handshake;
    logic [4:0]      n_norm;
    logic            next_is_last;

    // Handshake: a beat transfers on a rising edge where tvalid && tready; tvalid
    // stays high with stable tdata/tkeep/tlast until that edge, and never depends on tready.
    assign n_norm       = (iWORDS == 5'd0 || iWORDS > MAX_WORDS) ? MAX_WORDS : iWORDS;
    assign next_is_last = ((cnt_q + 5'd1) == (n_q - 5'd1));

    always_comb begin
        state_nx  = state_q;
        last_nx   = last_q;
        capture   = 1'b0;
        handshake = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (iSTATE_VLD) begin
                    capture  = 1'b1;
                    state_nx = SEND;
                    last_nx  = (n_norm == 5'd1);
                end
            end
            SEND: begin
                if (m_axis_tready) begin
                    handshake = 1'b1;
                    if (last_q) begin
                        state_nx = FIN;
                        last_nx  = 1'b0;
                    end else begin
                        last_nx = next_is_last;
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            state_q       <= IDLE;
            oSTATE_RDY    <= 1'b1;
            oBUSY         <= 1'b0;
            oDONE         <= 1'b0;
            m_axis_tvalid <= 1'b0;
            last_q        <= 1'b0;
            shreg_q       <= '0;
            n_q           <= MAX_WORDS;
            cnt_q         <= 5'd0;
        end else begin
            state_q       <= state_nx;
            oSTATE_RDY    <= (state_nx == IDLE);
            oBUSY         <= (state_nx == SEND);
            oDONE         <= (state_nx == FIN);
            m_axis_tvalid <= (state_nx == SEND);
            last_q        <= last_nx;
            if (capture) begin
                shreg_q <= iSTATE;
                n_q     <= n_norm;
                cnt_q   <= 5'd0;
            end else if (handshake) begin
                shreg_q <= {{LANE_W{1'b0}}, shreg_q[SW-1:LANE_W]};
                // The final beat leaves cnt at N-1 so it never wraps.
                if (!last_q) cnt_q <= cnt_q + 5'd1;
            end
        end
    end

    assign m_axis_tdata = shreg_q[LANE_W-1:0];
    assign m_axis_tlast = last_q;
    assign dbg_state    = state_q;

`ifdef KECCAK_TX_KEEP_EN
    logic [KW-1:0] keep_q, keep_nx, last_keep_q, keep_sel;

    assign keep_sel = (iLAST_KEEP == '0) ? {KW{1'b1}} : iLAST_KEEP;

    always_comb begin
        keep_nx = keep_q;
        if (capture)
            keep_nx = (n_norm == 5'd1) ? keep_sel : {KW{1'b1}};
        else if (handshake)
            keep_nx = (!last_q && next_is_last) ? last_keep_q : {KW{1'b1}};
    end

    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            keep_q      <= {KW{1'b1}};
            last_keep_q <= {KW{1'b1}};
        end else begin
            keep_q <= keep_nx;
            if (capture) last_keep_q <= keep_sel;
        end
    end

    assign m_axis_tkeep = keep_q;
`else
    logic unused_last_keep;
    assign unused_last_keep = ^iLAST_KEEP;
    assign m_axis_tkeep     = {KW{1'b1}};
`endif

endmodule

// File: tb/tb_keccak_axis_tx.sv
// Bench for keccak_axis_tx: table vectors, hand sequences and random transfers
// checked beat by beat against a lane-queue model of the expected stream.
module tb_keccak_axis_tx;

  localparam int EW = 64 + 8 + 1;
`ifdef KECCAK_TX_KEEP_EN
  localparam bit KEEP_EN = 1'b1;
`else
  localparam bit KEEP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1599:0] st_in = '0;
  logic          vld = 1'b0;
  logic [4:0]    words = 5'd0;
  logic [7:0]    lkeep = 8'hFF;
  logic          tready = 1'b1;
  logic          rdy, busy, done, tvalid, tlast;
  logic [63:0]   tdata;
  logic [7:0]    tkeep;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  int hs_count = 0;
  int rmode = 0;
  int rcyc = 0;
  logic stall_prev = 1'b0;
  logic done_expect = 1'b0;
  logic [63:0] prev_data = '0;
  logic prev_last = 1'b0;
  logic [7:0] prev_keep = '0;

  keccak_axis_tx dut (
    .iSYS_CLK(clk), .iSYS_RST(rst), .iSTATE(st_in), .iSTATE_VLD(vld),
    .iWORDS(words), .iLAST_KEEP(lkeep), .oSTATE_RDY(rdy), .oBUSY(busy),
    .oDONE(done), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast),
    .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1599:0] rand_state();
    logic [1599:0] r;
    for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic int norm_words(input logic [4:0] w);
    return (w == 5'd0 || w > 5'd25) ? 25 : int'(w);
  endfunction

  // reference model: the stream is simply lanes 0..n-1 of the captured state
  task automatic push_model(input logic [1599:0] st, input logic [4:0] w, input logic [7:0] k);
    int n;
    n = norm_words(w);
    for (int i = 0; i < n; i++) begin
      logic [7:0] kk;
      logic       is_last;
      is_last = (i == n - 1);
      kk = (KEEP_EN && is_last && k != 8'h00) ? k : 8'hFF;
      exp_q.push_back({is_last, kk, st[64*i +: 64]});
    end
  endtask

  // tready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  always @(posedge clk) begin
    #1;
    rcyc++;
    case (rmode)
      0:       tready = 1'b1;
      1:       tready = !((rcyc % 4 == 1) || (rcyc % 4 == 2));
      default: tready = 1'($urandom_range(0, 1));
    endcase
  end

  // scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      stall_prev  = 1'b0;
      done_expect = 1'b0;
    end else begin
      if (done_expect) begin
        check("done_pulse", 64'(done), 64'(1));
        check("valid_after_last", 64'(tvalid), 64'(0));
      end else if (done) begin
        check("spurious_done", 64'(done), 64'(0));
      end
      done_expect = 1'b0;
      if (stall_prev) begin
        check("hold_valid", 64'(tvalid), 64'(1));
        check("hold_data", tdata, prev_data);
        check("hold_last", 64'(tlast), 64'(prev_last));
        check("hold_keep", 64'(tkeep), 64'(prev_keep));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_beat: got data %0h want no beat", tdata);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("beat_data", tdata, e[63:0]);
          check("beat_keep", 64'(tkeep), 64'(e[71:64]));
          check("beat_last", 64'(tlast), 64'(e[72]));
        end
        hs_count++;
        done_expect = tlast;
      end
      stall_prev = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      prev_keep  = tkeep;
    end
  end

  // driver tasks
  task automatic start_xfer(input logic [1599:0] st, input logic [4:0] w, input logic [7:0] k);
    int g;
    g = 0;
    while (!rdy && g < 50) begin
      step;
      g++;
    end
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL start_wait: got oSTATE_RDY=0 want 1 within 50 cycles");
    end
    st_in = st;
    words = w;
    lkeep = k;
    vld   = 1'b1;
    push_model(st, w, k);
    step;
    vld = 1'b0;
    check("cap_latency", 64'(tvalid), 64'(1));
    st_in = rand_state();
    words = 5'($urandom);
    lkeep = 8'($urandom);
  endtask

  task automatic wait_done(input int n, input int hs0, input bit timed);
    int cyc;
    bit seen;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      step;
      cyc++;
      if (done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'(1));
    if (timed) check("latency", 64'(cyc), 64'(n));
    check("beat_count", 64'(hs_count - hs0), 64'(n));
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    step;
    check("rdy_after", 64'(rdy), 64'(1));
    check("busy_after", 64'(busy), 64'(0));
  endtask

  typedef struct {
    logic [4:0] w;
    logic [7:0] keep;
    int         rm;
    int         exp_n;
    bit         plan;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [1599:0] plan_st;
    logic [1599:0] st;
    int hs0;

    tbl[0] = '{5'd25, 8'hFF, 0, 25, 1'b1};
    tbl[1] = '{5'd17, 8'hFF, 0, 17, 1'b0};
    tbl[2] = '{5'd0,  8'hFF, 0, 25, 1'b0};
    tbl[3] = '{5'd31, 8'hFF, 2, 25, 1'b0};
    tbl[4] = '{5'd1,  8'h0F, 1, 1,  1'b0};
    tbl[5] = '{5'd4,  8'h0F, 0, 4,  1'b0};
    tbl[6] = '{5'd4,  8'h00, 1, 4,  1'b0};
    tbl[7] = '{5'd2,  8'h3C, 2, 2,  1'b0};

    plan_st = '0;
    plan_st[64*8 +: 64]  = 64'h80;
    plan_st[64*24 +: 64] = 64'h0600000000000000;

    // reset
    rst = 1'b1;
    repeat (3) step;
    check("rst_rdy", 64'(rdy), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_valid", 64'(tvalid), 64'(0));
    check("rst_last", 64'(tlast), 64'(0));
    check("rst_keep", 64'(tkeep), 64'hFF);
    check("rst_data", tdata, 64'h0);
    rst = 1'b0;
    step;

    // table vectors
    for (int i = 0; i < 8; i++) begin
      rmode = tbl[i].rm;
      st    = tbl[i].plan ? plan_st : rand_state();
      hs0   = hs_count;
      start_xfer(st, tbl[i].w, tbl[i].keep);
      wait_done(tbl[i].exp_n, hs0, rmode == 0);
    end

    // capture request mid-transfer must be ignored
    rmode = 1;
    hs0   = hs_count;
    start_xfer(rand_state(), 5'd10, 8'hFF);
    repeat (3) step;
    st_in = rand_state();
    words = 5'd3;
    vld   = 1'b1;
    step;
    vld = 1'b0;
    wait_done(10, hs0, 1'b0);
    repeat (2) step;
    check("ignored_vld_busy", 64'(busy), 64'(0));
    check("ignored_vld_valid", 64'(tvalid), 64'(0));

    // reset after beat 5, then a fresh transfer from lane 0
    rmode = 0;
    hs0   = hs_count;
    start_xfer(rand_state(), 5'd25, 8'hFF);
    for (int g = 0; g < 100 && (hs_count - hs0) < 6; g++) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    exp_q.delete();
    check("midrst_valid", 64'(tvalid), 64'(0));
    check("midrst_rdy", 64'(rdy), 64'(1));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_data", tdata, 64'h0);
    repeat (3) step;
    hs0 = hs_count;
    start_xfer(rand_state(), 5'd5, 8'hFF);
    wait_done(5, hs0, 1'b1);

    // random transfers
    rmode = 2;
    for (int i = 0; i < 20; i++) begin
      logic [4:0] w;
      w   = 5'($urandom_range(0, 31));
      hs0 = hs_count;
      start_xfer(rand_state(), w, 8'($urandom));
      wait_done(norm_words(w), hs0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
